// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: one shared tick prescaler feeding NUM_CH independent
// OFF / ON / BLINK / ONESHOT channels with runtime-programmable periods.
module led_blink_multi #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1_000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic [NUM_CH-1:0]   led,
    output logic [NUM_CH-1:0]   oneshot_done,
    output logic                tick
);

    localparam int unsigned PS     = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W   = (PS > 1) ? $clog2(PS) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PS - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    logic [PS_W-1:0]     r_ps;
    logic                r_tick;

    mode_t               r_mode   [NUM_CH];
    logic [PERIOD_W-1:0] r_period [NUM_CH];
    logic [PERIOD_W-1:0] r_cnt    [NUM_CH];
    logic [NUM_CH-1:0]   r_led;
    logic [NUM_CH-1:0]   r_done;

    mode_t               w_mode   [NUM_CH];
    logic [PERIOD_W-1:0] w_period [NUM_CH];
    logic [PERIOD_W-1:0] w_cnt    [NUM_CH];
    logic [NUM_CH-1:0]   w_led;
    logic [NUM_CH-1:0]   w_done;
    logic [NUM_CH-1:0]   w_wr;
    logic [PERIOD_W-1:0] w_cfg_period;
    mode_t               w_cfg_mode;

    // Prescaler: tick is registered, so it rises the cycle after the count hits PS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_ps == PS_MAX);
            if (r_ps == PS_MAX) begin
                r_ps <= '0;
            end else begin
                r_ps <= r_ps + PS_W'(1);
            end
        end
    end

    // Write decode; out-of-range channel indices match no channel and are dropped.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = cfg_we && (cfg_ch == 4'(i));
        end
    end

    assign w_cfg_period = (cfg_period == '0) ? PERIOD_ONE : cfg_period;
    assign w_cfg_mode   = mode_t'(cfg_mode);

    // Channel state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_mode[i]   <= MODE_OFF;
                r_period[i] <= PERIOD_ONE;
                r_cnt[i]    <= '0;
            end
            r_led  <= '0;
            r_done <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_mode[i]   <= w_mode[i];
                r_period[i] <= w_period[i];
                r_cnt[i]    <= w_cnt[i];
            end
            r_led  <= w_led;
            r_done <= w_done;
        end
    end

    // Per-channel next state: a write overrides (and swallows) a coincident tick.
    always_comb begin
        w_led  = r_led;
        w_done = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_mode[i]   = r_mode[i];
            w_period[i] = r_period[i];
            w_cnt[i]    = r_cnt[i];

            if (w_wr[i]) begin
                w_mode[i]   = w_cfg_mode;
                w_period[i] = w_cfg_period;
                w_cnt[i]    = '0;
                w_led[i]    = (w_cfg_mode != MODE_OFF);
            end else if (r_tick) begin
                unique case (r_mode[i])
                    MODE_BLINK: begin
                        if (r_cnt[i] == r_period[i] - PERIOD_ONE) begin
                            w_led[i] = ~r_led[i];
                            w_cnt[i] = '0;
                        end else begin
                            w_cnt[i] = r_cnt[i] + PERIOD_ONE;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (r_cnt[i] == r_period[i] - PERIOD_ONE) begin
                            w_led[i]  = 1'b0;
                            w_mode[i] = MODE_OFF;
                            w_cnt[i]  = '0;
                            w_done[i] = 1'b1;
                        end else begin
                            w_cnt[i] = r_cnt[i] + PERIOD_ONE;
                        end
                    end
                    default: begin
                        w_cnt[i] = '0;
                    end
                endcase
            end
        end
    end

    assign led          = r_led;
    assign oneshot_done = r_done;
    assign tick         = r_tick;

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi: expectations come from a tick-counting model
// pushed into a scoreboard queue and popped after each clock edge.
module tb_led_blink_multi;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_period;
    logic [3:0] led;
    logic [3:0] oneshot_done;
    logic       tick;

    led_blink_multi #(
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .NUM_CH  (4),
        .PERIOD_W(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_period  (cfg_period),
        .led         (led),
        .oneshot_done(oneshot_done),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic [3:0] done;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_fail;
    int   cyc;
    int   m_mode [4];
    int   m_w    [4];
    int   m_p    [4];

    function automatic logic tick_at(int k);
        return (k > 0) && (k % 10 == 0);
    endfunction

    // Ticks a channel written at edge w has consumed by edge k.
    function automatic int consumed(int w, int k);
        int n = 0;
        for (int e = w + 1; e <= k; e++) begin
            if (tick_at(e - 1)) n++;
        end
        return n;
    endfunction

    function automatic exp_t model(int k, string tag);
        exp_t r;
        int   m;
        r.tag  = tag;
        r.led  = '0;
        r.done = '0;
        r.tick = tick_at(k);
        for (int c = 0; c < 4; c++) begin
            m = consumed(m_w[c], k);
            case (m_mode[c])
                1: r.led[c] = 1'b1;
                2: r.led[c] = ((m / m_p[c]) % 2) == 0;
                3: begin
                    r.led[c]  = (m < m_p[c]);
                    r.done[c] = (m == m_p[c]) && (k > m_w[c]) && tick_at(k - 1);
                end
                default: r.led[c] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < 4; c++) begin
            m_mode[c] = 0;
            m_w[c]    = 0;
            m_p[c]    = 1;
        end
    endtask

    task automatic push_zero(string tag);
        exp_t e;
        e.tag  = tag;
        e.led  = '0;
        e.done = '0;
        e.tick = 1'b0;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        assert (led === e.led) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d led observed=%b expected=%b", e.tag, cyc, led, e.led);
        end
        n_vec++;
        assert (oneshot_done === e.done) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d oneshot_done observed=%b expected=%b", e.tag, cyc, oneshot_done, e.done);
        end
        n_vec++;
        assert (tick === e.tick) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d tick observed=%b expected=%b", e.tag, cyc, tick, e.tick);
        end
    endtask

    task automatic run_cycle(string tag);
        sb.push_back(model(cyc + 1, tag));
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic do_write(int ch, int mode, int per, string tag);
        cfg_we     = 1'b1;
        cfg_ch     = 4'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = 8'(per);
        if (ch < 4) begin
            m_mode[ch] = mode;
            m_w[ch]    = cyc + 1;
            m_p[ch]    = (per == 0) ? 1 : per;
        end
        run_cycle(tag);
        cfg_we = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_period = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        push_zero("reset");
        compare();
        rst = 1'b0;
        model_reset();

        repeat (45) run_cycle("idle");
        do_write(0, 2, 3, "w_ch0_blink");
        repeat (64) run_cycle("ch0_blink");
        do_write(2, 3, 2, "w_ch2_oneshot");
        repeat (49) run_cycle("ch2_oneshot");
        do_write(1, 2, 0, "w_ch1_blink_p0");
        repeat (29) run_cycle("ch1_blink_p0");
        do_write(1, 1, 5, "w_ch1_on");
        repeat (29) run_cycle("ch1_on");
        do_write(0, 2, 3, "w_ch0_on_tick");
        repeat (39) run_cycle("ch0_retrig");
        do_write(5, 1, 9, "w_bad_ch");
        repeat (9) run_cycle("bad_ch_hold");
        do_write(2, 3, 5, "w_ch2_oneshot5");
        repeat (14) run_cycle("mid_run");

        // Assert reset between clock edges; outputs must clear without waiting for clk.
        #3;
        rst = 1'b1;
        #1;
        push_zero("async_rst");
        compare();
        repeat (2) @(posedge clk);
        #1;
        push_zero("rst_hold");
        compare();
        rst = 1'b0;
        model_reset();
        repeat (25) run_cycle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
